// File: rtl/pwm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : pwm_pkg                                                           |
// | Desc   : Shared widths and config-word field positions for the PWM blocks. |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
package pwm_pkg;

  localparam int CCW      = 24;  // config word width
  localparam int DUTY_W   = 8;   // base duty width, period = 2**DUTY_W clocks
  localparam int SEQ_W    = 16;  // dither sequence length in periods
  localparam int DUTY_LSB = 16;  // cfg[DUTY_LSB +: DUTY_W] = base duty
  localparam int SEQ_LSB  = 0;   // cfg[SEQ_LSB  +: SEQ_W]  = dither sequence

endpackage
`default_nettype wire

// File: rtl/red_pitaya_pwm_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : red_pitaya_pwm_gen                                                |
// | Desc   : Sigma-delta dithered PWM, base duty plus a per-period extra bit.  |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module red_pitaya_pwm_gen #(
  parameter int CCW    = pwm_pkg::CCW,
  parameter int DUTY_W = pwm_pkg::DUTY_W,
  parameter int SEQ_W  = pwm_pkg::SEQ_W
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           en_i,
  input  logic [CCW-1:0] cfg_i,
  output logic           pwm_o,
  output logic           frame_o,
  output logic [CCW-1:0] cfg_o
);

  import pwm_pkg::*;

  localparam int            BW          = (SEQ_W > 1) ? $clog2(SEQ_W) : 1;
  localparam int            TW          = DUTY_W + 1;
  localparam logic [BW-1:0] C_BCNT_LAST = BW'(SEQ_W - 1);

  logic [DUTY_W-1:0] r_vcnt;
  logic [BW-1:0]     r_bcnt;
  logic [TW-1:0]     r_thr;
  logic [CCW-1:0]    r_cfg_q;
  logic              r_pwm;
  logic              r_frame;

  logic              w_vwrap;
  logic              w_fwrap;
  logic              w_load;
  logic [CCW-1:0]    w_cfg_next;
  logic [BW-1:0]     w_bcnt_next;
  logic [DUTY_W-1:0] w_duty;
  logic [SEQ_W-1:0]  w_seq;
  logic [TW-1:0]     w_thr_next;

  assign w_vwrap = &r_vcnt;
  assign w_fwrap = w_vwrap && (r_bcnt == C_BCNT_LAST);
  assign w_load  = !en_i || w_fwrap;

  // Threshold is prepared for the period about to start, from the config it
  // will run with, so a freshly loaded word takes effect in period 0.
  assign w_cfg_next  = w_load ? cfg_i : r_cfg_q;
  assign w_bcnt_next = w_load ? '0 : r_bcnt + 1'b1;
  assign w_duty      = w_cfg_next[DUTY_LSB +: DUTY_W];
  assign w_seq       = w_cfg_next[SEQ_LSB +: SEQ_W];
  assign w_thr_next  = {1'b0, w_duty} + TW'(w_seq[w_bcnt_next]);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_vcnt  <= '0;
      r_bcnt  <= '0;
      r_thr   <= '0;
      r_cfg_q <= '0;
      r_pwm   <= 1'b0;
      r_frame <= 1'b0;
    end else if (!en_i) begin
      r_vcnt  <= '0;
      r_bcnt  <= '0;
      r_thr   <= w_thr_next;
      r_cfg_q <= cfg_i;
      r_pwm   <= 1'b0;
      r_frame <= 1'b0;
    end else begin
      r_pwm   <= ({1'b0, r_vcnt} < r_thr);
      r_frame <= (r_vcnt == '0) && (r_bcnt == '0);
      r_vcnt  <= r_vcnt + 1'b1;
      if (w_vwrap) begin
        r_bcnt  <= w_bcnt_next;
        r_thr   <= w_thr_next;
        r_cfg_q <= w_cfg_next;
      end
    end
  end

  assign pwm_o   = r_pwm;
  assign frame_o = r_frame;
  assign cfg_o   = r_cfg_q;

endmodule
`default_nettype wire

// File: tb/tb_red_pitaya_pwm_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_red_pitaya_pwm_gen                                             |
// | Desc   : Directed self-checking bench for red_pitaya_pwm_gen.              |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_red_pitaya_pwm_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [23:0] cfg;
  logic        pwm;
  logic        frame;
  logic [23:0] cfg_rd;

  int n_checks = 0;
  int n_pass   = 0;

  red_pitaya_pwm_gen dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .en_i    (en),
    .cfg_i   (cfg),
    .pwm_o   (pwm),
    .frame_o (frame),
    .cfg_o   (cfg_rd)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(negedge clk);
  endtask

  // After this returns, the next tick samples output cycle 0 of a frame.
  task automatic start_run(input logic [23:0] c);
    en  = 1'b0;
    cfg = c;
    tick();
    tick();
    en  = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b0; cfg = 24'hABCDEF;
    repeat (3) tick();
    n_checks++; if (pwm !== 1'b0) $display("FAIL reset_pwm: got %b want 0", pwm); else n_pass++;
    n_checks++; if (frame !== 1'b0) $display("FAIL reset_frame: got %b want 0", frame); else n_pass++;
    n_checks++; if (cfg_rd !== 24'h0) $display("FAIL reset_cfg: got %h want 000000", cfg_rd); else n_pass++;
    rst = 1'b0;
    tick();
    n_checks++; if (cfg_rd !== 24'hABCDEF) $display("FAIL disabled_track: got %h want abcdef", cfg_rd); else n_pass++;
  endtask

  task automatic test_constant(input logic [23:0] c, input int exp_highs, input string nm);
    int highs = 0, nf = 0, badf = 0;
    start_run(c);
    for (int i = 0; i < 8192; i++) begin
      tick();
      highs += int'(pwm);
      if (frame === 1'b1) begin
        nf++;
        if (i % 4096 != 0) badf++;
      end
    end
    n_checks++; if (highs !== exp_highs) $display("FAIL %s_highs: got %0d want %0d", nm, highs, exp_highs); else n_pass++;
    n_checks++; if (nf !== 2) $display("FAIL %s_frames: got %0d want 2", nm, nf); else n_pass++;
    n_checks++; if (badf !== 0) $display("FAIL %s_frame_pos: got %0d misplaced want 0", nm, badf); else n_pass++;
  endtask

  task automatic test_half;
    int highs = 0, bad = 0;
    logic e;
    start_run(24'h800000);
    for (int i = 0; i < 4096; i++) begin
      tick();
      e = ((i % 256) < 128);
      highs += int'(pwm);
      if (pwm !== e) bad++;
      if (i == 0) begin
        n_checks++; if (frame !== 1'b1) $display("FAIL half_frame0: got %b want 1", frame); else n_pass++;
      end
    end
    n_checks++; if (bad !== 0) $display("FAIL half_pattern: got %0d bad cycles want 0", bad); else n_pass++;
    n_checks++; if (highs !== 2048) $display("FAIL half_highs: got %0d want 2048", highs); else n_pass++;
  endtask

  task automatic test_dither;
    int highs = 0, bad = 0, thr;
    start_run(24'h0F5555);
    for (int i = 0; i < 4096; i++) begin
      tick();
      thr = ((i / 256) % 2 == 0) ? 16 : 15;
      highs += int'(pwm);
      if (pwm !== ((i % 256) < thr)) bad++;
    end
    n_checks++; if (bad !== 0) $display("FAIL dither_pattern: got %0d bad cycles want 0", bad); else n_pass++;
    n_checks++; if (highs !== 248) $display("FAIL dither_highs: got %0d want 248", highs); else n_pass++;
  endtask

  task automatic test_cfg_switch;
    int bad = 0, highs2 = 0, thr;
    start_run(24'h400000);
    for (int i = 0; i < 4352; i++) begin
      tick();
      thr = (i < 4096) ? 64 : 192;
      if (pwm !== ((i % 256) < thr)) bad++;
      if (i >= 4096) highs2 += int'(pwm);
      if (i == 7 * 256 + 99) cfg = 24'hC00000;
      if (i == 4094) begin
        n_checks++; if (cfg_rd !== 24'h400000) $display("FAIL switch_cfg_before: got %h want 400000", cfg_rd); else n_pass++;
      end
      if (i == 4096) begin
        n_checks++; if (cfg_rd !== 24'hC00000) $display("FAIL switch_cfg_after: got %h want c00000", cfg_rd); else n_pass++;
        n_checks++; if (frame !== 1'b1) $display("FAIL switch_frame: got %b want 1", frame); else n_pass++;
      end
    end
    n_checks++; if (bad !== 0) $display("FAIL switch_pattern: got %0d bad cycles want 0", bad); else n_pass++;
    n_checks++; if (highs2 !== 192) $display("FAIL switch_new_period: got %0d want 192", highs2); else n_pass++;
  endtask

  task automatic test_async_reset;
    int bad = 0, nf = 0, badf = 0;
    logic e;
    start_run(24'h800000);
    for (int i = 0; i <= 3 * 256 + 10; i++) tick();
    n_checks++; if (pwm !== 1'b1) $display("FAIL arst_pre_pwm: got %b want 1", pwm); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++; if (pwm !== 1'b0) $display("FAIL arst_pwm: got %b want 0", pwm); else n_pass++;
    n_checks++; if (cfg_rd !== 24'h0) $display("FAIL arst_cfg: got %h want 000000", cfg_rd); else n_pass++;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4096 + 256; i++) begin
      tick();
      e = (i >= 4096) && ((i % 256) < 128);
      if (pwm !== e) bad++;
      if (frame === 1'b1) begin
        nf++;
        if (i % 4096 != 0) badf++;
      end
      if (i == 4096) begin
        n_checks++; if (cfg_rd !== 24'h800000) $display("FAIL arst_cfg_load: got %h want 800000", cfg_rd); else n_pass++;
      end
    end
    n_checks++; if (bad !== 0) $display("FAIL arst_pattern: got %0d bad cycles want 0", bad); else n_pass++;
    n_checks++; if (nf !== 2 || badf !== 0) $display("FAIL arst_frames: got %0d (%0d misplaced) want 2 (0)", nf, badf); else n_pass++;
  endtask

  task automatic test_enable_drop;
    int highs = 0, bad = 0, badf = 0;
    start_run(24'h800000);
    for (int i = 0; i <= 50; i++) tick();
    n_checks++; if (pwm !== 1'b1) $display("FAIL en_pre_pwm: got %b want 1", pwm); else n_pass++;
    en  = 1'b0;
    cfg = 24'h200001;
    tick();
    n_checks++; if (pwm !== 1'b0) $display("FAIL en_drop_pwm: got %b want 0", pwm); else n_pass++;
    tick();
    tick();
    n_checks++; if (cfg_rd !== 24'h200001) $display("FAIL en_cfg_track: got %h want 200001", cfg_rd); else n_pass++;
    n_checks++; if (frame !== 1'b0) $display("FAIL en_off_frame: got %b want 0", frame); else n_pass++;
    en = 1'b1;
    for (int i = 0; i < 256; i++) begin
      tick();
      highs += int'(pwm);
      if (pwm !== (i < 33)) bad++;
      if (i == 0) begin
        n_checks++; if (frame !== 1'b1) $display("FAIL en_frame0: got %b want 1", frame); else n_pass++;
      end else if (frame === 1'b1) badf++;
    end
    n_checks++; if (highs !== 33) $display("FAIL en_highs: got %0d want 33", highs); else n_pass++;
    n_checks++; if (bad !== 0 || badf !== 0) $display("FAIL en_pattern: got %0d bad / %0d stray frames want 0", bad, badf); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_constant(24'h000000, 0, "zero");
    test_constant(24'hFFFFFF, 8192, "full");
    test_half();
    test_dither();
    test_cfg_switch();
    test_async_reset();
    test_enable_drop();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
